eth_tx_arbiter: RTL and testbench
=================================

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, meaning the minimum idle clocks between frames on the shared TX path.
REQ-002 SHALL have parameter MAX_FRAME_CYCLES, default 1600, meaning the watchdog limit on clocks per frame.
REQ-003 SHALL have parameter START_TIMEOUT, default 64, meaning the clocks allowed from grant to the owner's first tx_en.
REQ-004 SHALL have parameter ARP_PRIORITY, default 1, where 1 = ARP fixed-high priority and 0 = round-robin.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (125 MHz TX byte clock).
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port arp_req, input, 1 bit: ARP sender level request, held until arp_grant.
REQ-008 SHALL have port arp_tx_en, input, 1 bit: ARP sender frame-valid.
REQ-009 SHALL have port arp_data, input, 8 bits: ARP sender byte.
REQ-010 SHALL have port udp_req, input, 1 bit: UDP sender level request, held until udp_grant.
REQ-011 SHALL have port udp_tx_en, input, 1 bit: UDP sender frame-valid.
REQ-012 SHALL have port udp_data, input, 8 bits: UDP sender byte.
REQ-013 SHALL have port arp_grant, output, 1 bit: one-clock start pulse to the ARP sender.
REQ-014 SHALL have port udp_grant, output, 1 bit: one-clock start pulse to the UDP sender.
REQ-015 SHALL have port tx_en, output, 1 bit: arbitrated frame-valid to the MII serializer.
REQ-016 SHALL have port tx_data, output, 8 bits: arbitrated byte to the serializer and CRC.
REQ-017 SHALL have port sel_arp, output, 1 bit: 1 when ARP is the current or last owner (drives the CRC data mux).
REQ-018 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-019 SHALL have port timeout_err, output, 1 bit: one-clock pulse on a start or frame timeout.

Function
REQ-020 SHALL implement the states IDLE, GRANT, FRAME and IFG.
REQ-021 In IDLE, on any request, SHALL select a winner, pulse its grant for exactly one clock, and go to GRANT on the next clock.
REQ-022 SHALL resolve simultaneous requests as follows: with ARP_PRIORITY=1, ARP wins; with ARP_PRIORITY=0, the winner alternates, with the last loser winning and UDP winning first after reset.
REQ-023 In GRANT, SHALL go to FRAME when the owner's tx_en rises, or pulse timeout_err and go to IDLE after START_TIMEOUT clocks with no rise.
REQ-024 In FRAME, SHALL drive tx_en/tx_data from the owner's tx_en/data, registered, with exactly one clock of latency.
REQ-025 The non-owner's tx_en and data SHALL be ignored, with no effect on the outputs.
REQ-026 In FRAME, when the owner's tx_en falls, SHALL go to IFG and load the gap counter with IFG_CYCLES.
REQ-027 The frame watchdog SHALL count clocks in FRAME.
  - On reaching MAX_FRAME_CYCLES: force tx_en=0 and tx_data=0 on the next clock, pulse timeout_err, and go to IFG.
  - The owner is then ignored until it drops tx_en.
REQ-028 In IFG, tx_en SHALL be 0; the counter decrements to 0, then the block goes to IDLE.
  - A new grant is therefore possible no earlier than IFG_CYCLES+1 clocks after the last tx_en=1 output clock.
REQ-029 Requests arriving during GRANT, FRAME or IFG SHALL be held pending (level) and arbitrated only in IDLE.
REQ-030 Outside FRAME, tx_data SHALL be 8'h00 and tx_en SHALL be 0.
REQ-031 Counters SHALL be sized to hold their parameter values, and SHALL saturate with no wrap.

Reset
REQ-032 While rst_n=0, SHALL hold state=IDLE and all of the following at 0: tx_en, tx_data, arp_grant, udp_grant, busy, timeout_err, counters and sel_arp; the round-robin pointer is set to UDP-first.
REQ-033 Reset asserted mid-frame SHALL drop tx_en asynchronously.
  - After release, the block starts in IDLE with no IFG enforced.

Verification
REQ-034 Simultaneous arp_req=udp_req=1 with ARP_PRIORITY=1 -> arp_grant pulses; ARP 42-byte frame appears on tx_en/tx_data 1 clock delayed; then 12 IFG clocks; then udp_grant.
REQ-035 ARP_PRIORITY=0 with both requests held for 4 frames -> grant order is UDP, ARP, UDP, ARP.
REQ-036 Grant issued but the owner never raises tx_en -> timeout_err pulse at 64 clocks after grant; back in IDLE; the other request is then served.
REQ-037 UDP holds tx_en for 2000 clocks -> tx_en output forced low after 1600 clocks; one timeout_err pulse; arp_req served only after UDP drops tx_en and the IFG elapses.
REQ-038 udp_tx_en toggles while ARP owns the path -> tx_data equals arp_data delayed by 1 clock with no glitch.
REQ-039 rst_n pulsed low mid-frame -> tx_en=0 immediately; after release, a pending request is granted on the first clock in IDLE.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Shares one Ethernet TX byte path between an ARP sender and a
//               UDP sender. A requester gets a one-clock grant pulse. The
//               owner's frame is then forwarded with one clock of latency,
//               followed by an enforced inter-frame gap. A start watchdog
//               covers the time from grant to the owner's first tx_en. A
//               frame watchdog cuts frames that run too long.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   125 MHz TX byte clock
//   rst_n        in   asynchronous active-low reset
//   arp_req      in   ARP sender level request, held until arp_grant
//   arp_tx_en    in   ARP sender frame-valid
//   arp_data     in   ARP sender byte
//   udp_req      in   UDP sender level request, held until udp_grant
//   udp_tx_en    in   UDP sender frame-valid
//   udp_data     in   UDP sender byte
//   arp_grant    out  one-clock start pulse to the ARP sender
//   udp_grant    out  one-clock start pulse to the UDP sender
//   tx_en        out  arbitrated frame-valid to the MII serializer
//   tx_data      out  arbitrated byte to the serializer and CRC
//   sel_arp      out  ARP is the current or last owner (CRC data mux select)
//   busy         out  arbiter is not idle
//   timeout_err  out  one-clock pulse on a start or frame timeout
// ============================================================================
module eth_tx_arbiter #(
  parameter int IFG_CYCLES       = 12,
  parameter int MAX_FRAME_CYCLES = 1600,
  parameter int START_TIMEOUT    = 64,
  parameter int ARP_PRIORITY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arp_req,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_data,
  input  logic       udp_req,
  input  logic       udp_tx_en,
  input  logic [7:0] udp_data,
  output logic       arp_grant,
  output logic       udp_grant,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       sel_arp,
  output logic       busy,
  output logic       timeout_err
);

  // Counter widths are sized to hold the parameter values themselves.
  localparam int ST_W = (START_TIMEOUT    > 0) ? $clog2(START_TIMEOUT + 1)    : 1;
  localparam int FC_W = (MAX_FRAME_CYCLES > 0) ? $clog2(MAX_FRAME_CYCLES + 1) : 1;
  localparam int GC_W = (IFG_CYCLES       > 0) ? $clog2(IFG_CYCLES + 1)       : 1;

  localparam logic [ST_W-1:0] C_START_LAST = ST_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
  localparam logic [FC_W-1:0] C_FRAME_MAX  = FC_W'(MAX_FRAME_CYCLES);
  localparam logic [GC_W-1:0] C_IFG_LOAD   = GC_W'(IFG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_FRAME = 2'd2,
    S_IFG   = 2'd3
  } state_t;

  state_t          state_q;
  logic            tx_en_q;
  logic [7:0]      tx_data_q;
  logic            arp_grant_q;
  logic            udp_grant_q;
  logic            owner_arp_q;   // current/last owner, doubles as sel_arp
  logic            busy_q;
  logic            timeout_err_q;
  logic [ST_W-1:0] start_cnt_q;
  logic [FC_W-1:0] frame_cnt_q;   // tx_en=1 output clocks in this frame
  logic [GC_W-1:0] gap_cnt_q;
  logic            wd_hold_q;     // frame was cut; wait for owner to drop tx_en
  logic            rr_arp_q;      // round-robin: ARP wins the next tie

  logic            owner_tx_en_w;
  logic [7:0]      owner_data_w;
  logic            win_arp_w;

  // Only the owner's lane reaches the datapath; the other lane is ignored.
  always_comb begin
    owner_tx_en_w = owner_arp_q ? arp_tx_en : udp_tx_en;
    owner_data_w  = owner_arp_q ? arp_data  : udp_data;
  end

  // Winner selection. A lone requester always wins; ties go to ARP in
  // fixed-priority mode or follow the round-robin pointer otherwise.
  always_comb begin
    if (ARP_PRIORITY != 0) begin
      win_arp_w = arp_req;
    end else begin
      win_arp_w = arp_req & (~udp_req | rr_arp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tx_en_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      arp_grant_q   <= 1'b0;
      udp_grant_q   <= 1'b0;
      owner_arp_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      start_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      wd_hold_q     <= 1'b0;
      rr_arp_q      <= 1'b0;
    end else begin
      // Pulses default low every clock.
      arp_grant_q   <= 1'b0;
      udp_grant_q   <= 1'b0;
      timeout_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          if (arp_req || udp_req) begin
            owner_arp_q <= win_arp_w;
            arp_grant_q <= win_arp_w;
            udp_grant_q <= ~win_arp_w;
            // The loser of this round is favoured next time.
            rr_arp_q    <= ~win_arp_w;
            start_cnt_q <= '0;
            state_q     <= S_GRANT;
            busy_q      <= 1'b1;
          end
        end

        S_GRANT: begin
          if (owner_tx_en_w) begin
            // The first byte is captured on the same edge as the state change
            // so the output trails the owner by exactly one clock.
            tx_en_q     <= 1'b1;
            tx_data_q   <= owner_data_w;
            frame_cnt_q <= FC_W'(1);
            start_cnt_q <= '0;
            state_q     <= S_FRAME;
          end else if (start_cnt_q >= C_START_LAST) begin
            timeout_err_q <= 1'b1;
            start_cnt_q   <= '0;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end else begin
            start_cnt_q <= start_cnt_q + ST_W'(1);
          end
        end

        S_FRAME: begin
          if (!owner_tx_en_w) begin
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            frame_cnt_q <= '0;
            gap_cnt_q   <= C_IFG_LOAD;
            state_q     <= S_IFG;
          end else if (frame_cnt_q >= C_FRAME_MAX) begin
            // Watchdog cut: the gap only starts once the owner lets go.
            tx_en_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b1;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= C_IFG_LOAD;
            wd_hold_q     <= 1'b1;
            state_q       <= S_IFG;
          end else begin
            tx_en_q     <= 1'b1;
            tx_data_q   <= owner_data_w;
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
          end
        end

        S_IFG: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          if (wd_hold_q) begin
            if (!owner_tx_en_w) begin
              wd_hold_q <= 1'b0;
              gap_cnt_q <= C_IFG_LOAD;
            end
          end else if (gap_cnt_q <= GC_W'(1)) begin
            // IFG occupies IFG_CYCLES clocks (at least one).
            gap_cnt_q <= '0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GC_W'(1);
          end
        end

        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
        end
      endcase
    end
  end

  assign arp_grant   = arp_grant_q;
  assign udp_grant   = udp_grant_q;
  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign sel_arp     = owner_arp_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_arbiter
// Description : Self-checking bench for eth_tx_arbiter. One instance runs in
//               ARP fixed-priority mode and one in round-robin mode. Driven
//               bytes that are expected on tx_data are queued and compared by
//               a monitor as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

  localparam int IFG  = 12;
  localparam int MAXF = 1600;
  localparam int STO  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arp_req, arp_tx_en, udp_req, udp_tx_en;
  logic [7:0] arp_data, udp_data;
  logic       arp_grant, udp_grant, tx_en, sel_arp, busy, timeout_err;
  logic [7:0] tx_data;

  logic       r_arp_req, r_arp_tx_en, r_udp_req, r_udp_tx_en;
  logic [7:0] r_arp_data, r_udp_data;
  logic       r_arp_grant, r_udp_grant, r_tx_en, r_sel_arp, r_busy, r_timeout_err;
  logic [7:0] r_tx_data;

  int         checks   = 0;
  int         failures = 0;
  int         terr_cnt = 0;
  int         r_terr_cnt = 0;
  logic [7:0] sb_q[$];
  logic       ord_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  eth_tx_arbiter #(
    .IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAXF), .START_TIMEOUT(STO), .ARP_PRIORITY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_req(arp_req), .arp_tx_en(arp_tx_en), .arp_data(arp_data),
    .udp_req(udp_req), .udp_tx_en(udp_tx_en), .udp_data(udp_data),
    .arp_grant(arp_grant), .udp_grant(udp_grant),
    .tx_en(tx_en), .tx_data(tx_data), .sel_arp(sel_arp),
    .busy(busy), .timeout_err(timeout_err)
  );

  eth_tx_arbiter #(
    .IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAXF), .START_TIMEOUT(STO), .ARP_PRIORITY(0)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .arp_req(r_arp_req), .arp_tx_en(r_arp_tx_en), .arp_data(r_arp_data),
    .udp_req(r_udp_req), .udp_tx_en(r_udp_tx_en), .udp_data(r_udp_data),
    .arp_grant(r_arp_grant), .udp_grant(r_udp_grant),
    .tx_en(r_tx_en), .tx_data(r_tx_data), .sel_arp(r_sel_arp),
    .busy(r_busy), .timeout_err(r_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every tx_en=1 byte must match the head of the scoreboard; idle
  // bytes must be zero.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      chk("sb_byte_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        chk("tx_data", tx_data, mon_exp);
      end
    end else begin
      chk("tx_data_idle_zero", tx_data, 8'h00);
    end
    if (timeout_err === 1'b1)   terr_cnt++;
    if (r_timeout_err === 1'b1) r_terr_cnt++;
  end

  // Inputs are driven and outputs read 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit rr, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      n++;
      if (rr ? (r_arp_grant | r_udp_grant) : (arp_grant | udp_grant)) begin
        got = 1'b1;
        break;
      end
    end
    chk(rr ? "rr_grant_seen" : "grant_seen", got, 1);
  endtask

  task automatic wait_idle(input bit rr);
    for (int k = 0; k < 300; k++) begin
      if (!(rr ? r_busy : busy)) break;
      step();
    end
    chk(rr ? "rr_idle" : "idle", rr ? r_busy : busy, 0);
  endtask

  // Owner streams len bytes then drops tx_en; every byte is expected out.
  task automatic send_frame(input bit is_arp, input int len);
    for (int i = 0; i < len; i++) begin
      if (is_arp) begin
        arp_tx_en = 1'b1; arp_data = 8'($urandom); sb_q.push_back(arp_data);
      end else begin
        udp_tx_en = 1'b1; udp_data = 8'($urandom); sb_q.push_back(udp_data);
      end
      step();
    end
    arp_tx_en = 1'b0; arp_data = 8'h00;
    udp_tx_en = 1'b0; udp_data = 8'h00;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  n;
    int  t0;
    bit  early;
    bit  got;

    rst_n = 1'b0;
    arp_req = 0; arp_tx_en = 0; arp_data = 0; udp_req = 0; udp_tx_en = 0; udp_data = 0;
    r_arp_req = 0; r_arp_tx_en = 0; r_arp_data = 0; r_udp_req = 0; r_udp_tx_en = 0; r_udp_data = 0;
    repeat (3) step();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_arp_grant", arp_grant, 0);
    chk("rst_udp_grant", udp_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_sel_arp", sel_arp, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Simultaneous requests, fixed priority: ARP first, 42-byte frame with
    // the UDP lane toggling underneath, then the gap, then UDP.
    arp_req = 1; udp_req = 1;
    step();
    chk("prio_arp_grant", arp_grant, 1);
    chk("prio_udp_grant", udp_grant, 0);
    chk("prio_sel_arp", sel_arp, 1);
    chk("prio_busy", busy, 1);
    arp_req = 0;
    for (int i = 0; i < 42; i++) begin
      arp_tx_en = 1'b1; arp_data = 8'($urandom); sb_q.push_back(arp_data);
      udp_tx_en = i[0]; udp_data = 8'($urandom);
      step();
      if (i == 0) begin
        chk("grant_one_clock", arp_grant, 0);
        chk("first_byte_latency", tx_en, 1);
      end
    end
    arp_tx_en = 0; arp_data = 0; udp_tx_en = 0; udp_data = 0;
    // From the clock the owner drops tx_en: 1 clock to enter IFG, 12 IFG
    // clocks, 1 IDLE clock that registers the grant.
    wait_grant(0, n);
    chk("ifg_to_udp_grant", n, IFG + 2);
    chk("udp_grant_after_ifg", udp_grant, 1);
    chk("sel_udp", sel_arp, 0);
    chk("arp_frame_drained", sb_q.size(), 0);
    udp_req = 0;
    send_frame(0, 20);
    wait_idle(0);

    // Round-robin instance, both requests held for four frames.
    ord_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    r_arp_req = 1; r_udp_req = 1;
    for (int f = 0; f < 4; f++) begin
      wait_grant(1, n);
      got = r_arp_grant;
      chk("rr_order", got, ord_q.pop_front());
      chk("rr_grant_exclusive", r_udp_grant, !got);
      chk("rr_sel_arp", r_sel_arp, got);
      for (int b = 0; b < 4; b++) begin
        if (got) begin r_arp_tx_en = 1; r_arp_data = 8'(8'hA0 + f); end
        else     begin r_udp_tx_en = 1; r_udp_data = 8'(8'hA0 + f); end
        step();
        if (b == 0) begin
          chk("rr_tx_en", r_tx_en, 1);
          chk("rr_tx_data", r_tx_data, 8'(8'hA0 + f));
        end
      end
      r_arp_tx_en = 0; r_udp_tx_en = 0; r_arp_data = 0; r_udp_data = 0;
      if (f == 3) begin r_arp_req = 0; r_udp_req = 0; end
    end
    wait_idle(1);

    // Start timeout: ARP granted but never starts; UDP served afterwards.
    arp_req = 1; udp_req = 1;
    step();
    chk("sto_arp_grant", arp_grant, 1);
    arp_req = 0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      n++;
      if (timeout_err) break;
    end
    chk("sto_latency", n, STO);
    chk("sto_back_idle", busy, 0);
    step();
    chk("sto_pulse_one_clock", timeout_err, 0);
    chk("sto_udp_served", udp_grant, 1);
    udp_req = 0;
    send_frame(0, 10);
    wait_idle(0);

    // Frame watchdog: UDP holds tx_en for 2000 clocks, ARP waiting.
    udp_req = 1;
    step();
    chk("wd_udp_grant", udp_grant, 1);
    udp_req = 0; arp_req = 1;
    t0 = terr_cnt; early = 0;
    for (int i = 0; i < 2000; i++) begin
      udp_tx_en = 1'b1; udp_data = 8'($urandom);
      if (i < MAXF) sb_q.push_back(udp_data);
      step();
      if (arp_grant) early = 1;
      if (i == MAXF - 1) chk("wd_last_byte_on", tx_en, 1);
      if (i == MAXF) begin
        chk("wd_forced_low", tx_en, 0);
        chk("wd_timeout_err", timeout_err, 1);
      end
    end
    chk("wd_no_early_grant", early, 0);
    udp_tx_en = 0; udp_data = 0;
    wait_grant(0, n);
    chk("wd_drop_to_arp_grant", n, IFG + 2);
    chk("wd_arp_grant", arp_grant, 1);
    chk("wd_single_pulse", terr_cnt - t0, 1);
    arp_req = 0;
    send_frame(1, 8);
    wait_idle(0);

    // Reset mid-frame, ARP pending; granted on the first clock after release.
    udp_req = 1;
    step();
    chk("rst_udp_grant", udp_grant, 1);
    udp_req = 0; arp_req = 1;
    udp_tx_en = 1; udp_data = 8'($urandom); sb_q.push_back(udp_data);
    step();
    chk("rst_frame_on", tx_en, 1);
    udp_data = 8'($urandom);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_en", tx_en, 0);
    chk("async_rst_tx_data", tx_data, 8'h00);
    chk("async_rst_busy", busy, 0);
    udp_tx_en = 0; udp_data = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_arp_grant", arp_grant, 1);
    arp_req = 0;
    send_frame(1, 5);
    wait_idle(0);

    chk("sb_empty_end", sb_q.size(), 0);
    chk("timeout_total", terr_cnt, 2);
    chk("rr_no_timeout", r_terr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
